// File: rtl/gbuff_stream_reader.sv
// Read-side master for the single-port global buffer: issues LEN sequential reads
// from BASE and streams the returned words out through a 2-entry skid FIFO.
module gbuff_stream_reader #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned LEN_BITS  = 9
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [ADDR_BITS-1:0] base_i,
  input  logic [LEN_BITS-1:0]  len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 gb_wr_en_o,
  output logic [ADDR_BITS-1:0] gb_index_o,
  input  logic [DATA_BITS-1:0] gb_data_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [DATA_BITS-1:0] m_data_o,
  output logic                 m_last_o
);

  localparam int unsigned FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic                 last;
    logic [DATA_BITS-1:0] data;
  } entry_t;

  state_t               state;
  state_t               state_nx;
  logic [ADDR_BITS-1:0] addr;
  logic [ADDR_BITS-1:0] idx_hold;
  logic [LEN_BITS-1:0]  issue_left;
  logic                 inflight;
  logic                 inflight_last;
  entry_t               fifo_mem [FIFO_DEPTH];
  logic                 rd_ptr;
  logic                 wr_ptr;
  logic [1:0]           fifo_cnt;
  logic [2:0]           occ;
  logic                 pop;
  logic                 push;
  logic                 issue;
  logic                 head_last;

  assign gb_wr_en_o = 1'b0;
  assign busy_o     = (state == S_RUN);
  assign done_o     = (state == S_DONE);
  assign m_valid_o  = (fifo_cnt != 2'd0);
  assign m_data_o   = fifo_mem[rd_ptr].data;
  assign head_last  = fifo_mem[rd_ptr].last;
  assign m_last_o   = m_valid_o & head_last;

  assign pop  = m_valid_o & m_ready_i;
  assign push = inflight;

  // Credit check: words held plus the one in flight, minus this cycle's pop, must leave room.
  assign occ   = 3'(fifo_cnt) + 3'(inflight) - 3'(pop);
  assign issue = (state == S_RUN) && !rst_i && (issue_left != '0) && (occ < 3'(FIFO_DEPTH));

  // The buffer samples the index at the end of the issue cycle, so the address is driven
  // straight through on issue and otherwise held at the last issued value.
  assign gb_index_o = rst_i ? '0 : (issue ? addr : idx_hold);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          state_nx = (len_i == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (pop && head_last) begin
          state_nx = S_DONE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Address generation, in-flight tracking and FIFO pointers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr          <= '0;
      idx_hold      <= '0;
      issue_left    <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      fifo_cnt      <= 2'd0;
    end else begin
      if ((state == S_IDLE) && start_i) begin
        addr       <= base_i;
        issue_left <= len_i;
      end else if (issue) begin
        addr       <= addr + ADDR_BITS'(1);
        issue_left <= issue_left - LEN_BITS'(1);
        idx_hold   <= addr;
      end
      inflight      <= issue;
      inflight_last <= issue && (issue_left == LEN_BITS'(1));
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
    end
  end

  // Storage needs no reset: contents are only visible while fifo_cnt says they are valid.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      fifo_mem[wr_ptr] <= '{last: inflight_last, data: gb_data_i};
    end
  end

endmodule

// File: tb/tb_gbuff_stream_reader.sv
// Bench for gbuff_stream_reader: behavioural buffer plus a word-index reference model
// checking stream order, data, last tagging, busy/done timing and backpressure stability.
module tb_gbuff_stream_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] base_in;
  logic [8:0] len_in;
  logic       busy;
  logic       done;
  logic       gb_wr_en;
  logic [7:0] gb_index;
  logic [7:0] gb_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;

  logic [7:0] mem [256];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) gb_data <= mem[gb_index];

  gbuff_stream_reader dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .base_i     (base_in),
    .len_i      (len_in),
    .busy_o     (busy),
    .done_o     (done),
    .gb_wr_en_o (gb_wr_en),
    .gb_index_o (gb_index),
    .gb_data_i  (gb_data),
    .m_valid_o  (m_valid),
    .m_ready_i  (m_ready),
    .m_data_o   (m_data),
    .m_last_o   (m_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one burst. mode 0: ready tied high; 1: toggling with a 5-cycle stall; 2: random.
  // Word k must equal mem[(base+k) mod 256]; done pulses the cycle after the last handshake.
  task automatic run_burst(input logic [7:0] base, input logic [8:0] len, input int mode,
                           input bit restart, input int abort_at);
    int got = 0;
    int done_cyc;
    int n = int'(len);
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic [7:0] pd = '0;
    logic pl = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; base_in = base; len_in = len; m_ready = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    check("idle_valid", 32'(m_valid), 0);
    done_cyc = (n == 0) ? 1 : -1;
    for (int cyc = 1; ; cyc++) begin
      @(posedge clk); #1;
      start = restart && (cyc == 2 || cyc == 4);
      base_in = ~base;
      len_in = len + 9'd3;
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = (cyc % 2 == 1) && !(cyc >= 8 && cyc <= 12);
        default: m_ready = ($urandom % 4) != 0;
      endcase
      @(negedge clk);
      check("wr_en", 32'(gb_wr_en), 0);
      check("busy", 32'(busy), 32'(n != 0 && got < n));
      check("done", 32'(done), 32'(cyc == done_cyc));
      if (mode == 0) check("valid_timing", 32'(m_valid), 32'(cyc >= 3 && cyc <= n + 2));
      if (got >= n) check("valid_after_end", 32'(m_valid), 0);
      if (pv && !pr) begin
        check("stall_valid", 32'(m_valid), 1);
        check("stall_data", 32'(m_data), 32'(pd));
        check("stall_last", 32'(m_last), 32'(pl));
      end
      if (m_valid && got < n) begin
        check("data", 32'(m_data), 32'(mem[8'(int'(base) + got)]));
        check("last", 32'(m_last), 32'(got == n - 1));
      end
      pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
      if (m_valid && m_ready) begin
        got++;
        if (got == n) done_cyc = cyc + 1;
        if (abort_at != 0 && got == abort_at) return;
      end
      if (cyc == done_cyc) break;
      if (cyc > 4 * n + 40) begin
        check("timeout_words", 32'(got), 32'(n));
        break;
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("post_done", 32'(done), 0);
    check("post_busy", 32'(busy), 0);
    check("post_valid", 32'(m_valid), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_in = '0; len_in = '0; m_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_valid", 32'(m_valid), 0);
    check("rst_last", 32'(m_last), 0);
    check("rst_index", 32'(gb_index), 0);
    check("rst_wr_en", 32'(gb_wr_en), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);

    // Identity buffer, ready tied high.
    run_burst(8'd4, 9'd5, 0, 1'b0, 0);

    // Random contents from here on; address wrap across the top of the buffer.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    run_burst(8'd254, 9'd4, 0, 1'b0, 0);

    // Toggling ready with a long stall.
    run_burst(8'($urandom), 9'd8, 1, 1'b0, 0);

    // Empty burst.
    run_burst(8'($urandom), 9'd0, 0, 1'b0, 0);

    // Start re-pulsed while busy must be ignored.
    run_burst(8'($urandom), 9'd6, 2, 1'b1, 0);

    // Reset after the third word of a 10-word burst.
    run_burst(8'($urandom), 9'd10, 0, 1'b0, 3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_valid", 32'(m_valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_index", 32'(gb_index), 0);
    repeat (3) begin
      @(negedge clk);
      check("abort_quiet_valid", 32'(m_valid), 0);
      check("abort_quiet_done", 32'(done), 0);
    end
    run_burst(8'd0, 9'd2, 0, 1'b0, 0);

    // Random bursts under random backpressure, including one longer than the buffer.
    for (int t = 0; t < 4; t++) begin
      run_burst(8'($urandom), 9'($urandom_range(1, 20)), 2, 1'b0, 0);
    end
    run_burst(8'($urandom), 9'd300, 2, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
